// File: rtl/user_lock_pkg.sv
// Shared types for the user-locked register bank: request opcodes and slot states.
package user_lock_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_CLAIM   = 2'd1,
    OP_RELEASE = 2'd2,
    OP_LOCK    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } st_e;

endpackage

// File: rtl/user_lock_slot.sv
// One ownable register: FREE/OWNED/LOCKED FSM with owner ID and data storage.
module user_lock_slot
  import user_lock_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int USR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_i,
  input  op_e               op_i,
  input  logic [USR_W-1:0]  usr_id_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              owned_o,
  output logic              locked_o
);

  st_e               state_q, state_d;
  logic [USR_W-1:0]  owner_q, owner_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FREE;
      owner_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
    end
  end

  // Only CLAIM is legal on a free slot; everything else needs an owner match.
  always_comb begin
    ok      = 1'b0;
    state_d = state_q;
    owner_d = owner_q;
    data_d  = data_q;
    case (op_i)
      OP_CLAIM: ok = (state_q == ST_FREE);
      default:  ok = (state_q == ST_OWNED) && (usr_id_i == owner_q);
    endcase
    if (sel_i && ok) begin
      case (op_i)
        OP_CLAIM: begin
          state_d = ST_OWNED;
          owner_d = usr_id_i;
        end
        OP_WRITE: data_d = data_i;
        OP_RELEASE: begin
          state_d = ST_FREE;
          owner_d = '0;
          data_d  = '0;
        end
        OP_LOCK: state_d = ST_LOCKED;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_o    = sel_i & ok;
    data_o   = data_q;
    owned_o  = (state_q == ST_OWNED) || (state_q == ST_LOCKED);
    locked_o = (state_q == ST_LOCKED);
  end

endmodule

// File: rtl/user_locked_regfile.sv
// Bank of user-ownable registers with claim/release/lock, request responses,
// a saturating rejection counter and a registered read port.
module user_locked_regfile
  import user_lock_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  parameter  int USR_W    = 2,
  parameter  int CNT_W    = 8,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [1:0]                 req_op,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [USR_W-1:0]           usr_id,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] data_out,
  output logic [NUM_REGS-1:0]        owned_vec,
  output logic [NUM_REGS-1:0]        locked_vec,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam logic [ADDR_W:0]  NREG_L  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                           in_range;
  logic                           req_err;
  logic [NUM_REGS-1:0]            sel;
  logic [NUM_REGS-1:0]            slot_ack;
  logic [NUM_REGS-1:0][DATA_W-1:0] slot_data;
  op_e                            op;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;

  assign op       = op_e'(req_op);
  assign in_range = ({1'b0, req_addr} < NREG_L);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    // Reset gating keeps a request in a reset cycle from ever being acked.
    assign sel[i] = req_valid & ~rst & in_range & (req_addr == ADDR_W'(i));

    user_lock_slot #(
      .DATA_W (DATA_W),
      .USR_W  (USR_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .sel_i    (sel[i]),
      .op_i     (op),
      .usr_id_i (usr_id),
      .data_i   (data_in),
      .ack_o    (slot_ack[i]),
      .data_o   (slot_data[i]),
      .owned_o  (owned_vec[i]),
      .locked_o (locked_vec[i])
    );

    assign data_out[i*DATA_W +: DATA_W] = slot_data[i];
  end

  // Out-of-range requests select no slot, so they fall out as "no ack".
  assign req_err = ~(|slot_ack);

  always_comb begin
    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid & req_err;
    err_cnt_d   = err_cnt_q;
    if (req_valid && req_err && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Reads see the pre-edge slot contents, giving read-before-write ordering.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data_d = slot_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_user_locked_regfile.sv
// Directed bench: default 4-slot bank plus a 3-slot bank with a 2-bit error counter.
module tb_user_locked_regfile;
  import user_lock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;

  // Instance A: defaults (4 slots, 8-bit counter)
  logic        rst, req_valid, rsp_valid, rsp_err;
  logic [1:0]  req_op, req_addr, usr_id, rd_addr;
  logic [7:0]  data_in, rd_data, err_cnt;
  logic [31:0] data_out;
  logic [3:0]  owned_vec, locked_vec;

  // Instance B: 3 slots, 2-bit counter
  logic        rst_b, req_valid_b, rsp_valid_b, rsp_err_b;
  logic [1:0]  req_op_b, req_addr_b, usr_id_b, rd_addr_b, err_cnt_b;
  logic [7:0]  data_in_b, rd_data_b;
  logic [23:0] data_out_b;
  logic [2:0]  owned_vec_b, locked_vec_b;

  user_locked_regfile u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .usr_id(usr_id), .data_in(data_in), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out), .owned_vec(owned_vec),
    .locked_vec(locked_vec), .err_cnt(err_cnt)
  );

  user_locked_regfile #(.NUM_REGS(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_op(req_op_b), .req_addr(req_addr_b),
    .usr_id(usr_id_b), .data_in(data_in_b), .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .data_out(data_out_b), .owned_vec(owned_vec_b),
    .locked_vec(locked_vec_b), .err_cnt(err_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input op_e op, input logic [1:0] addr, input logic [1:0] usr,
                       input logic [7:0] d);
    req_valid = 1'b1; req_op = op; req_addr = addr; usr_id = usr; data_in = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic req_b(input op_e op, input logic [1:0] addr, input logic [1:0] usr,
                       input logic [7:0] d);
    req_valid_b = 1'b1; req_op_b = op; req_addr_b = addr; usr_id_b = usr; data_in_b = d;
    step();
    req_valid_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; usr_id = '0; data_in = '0; rd_addr = '0;
    rst_b = 1'b1; req_valid_b = 1'b0; req_op_b = '0; req_addr_b = '0; usr_id_b = '0;
    data_in_b = '0; rd_addr_b = '0;
    step(); step();
    rst = 1'b0; rst_b = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      step();
      chk($sformatf("rst_rd%0d", i), 32'(rd_data), 32'h0);
    end
    chk("rst_owned", 32'(owned_vec), 32'h0);
    chk("rst_locked", 32'(locked_vec), 32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
    chk("rst_rspv", 32'(rsp_valid), 32'h0);
    chk("rst_dout", data_out, 32'h0);

    // User 2 claims and writes slot 1
    req_a(OP_CLAIM, 2'd1, 2'd2, 8'h00);
    chk("claim_rspv", 32'(rsp_valid), 32'h1);
    chk("claim_err", 32'(rsp_err), 32'h0);
    chk("claim_owned", 32'(owned_vec), 32'h2);
    req_a(OP_WRITE, 2'd1, 2'd2, 8'hA5);
    chk("wr_rspv", 32'(rsp_valid), 32'h1);
    chk("wr_err", 32'(rsp_err), 32'h0);
    chk("wr_data", 32'(data_out[15:8]), 32'hA5);

    // Non-owner write and claim
    req_a(OP_WRITE, 2'd1, 2'd1, 8'h3C);
    chk("nown_wr_err", 32'(rsp_err), 32'h1);
    chk("nown_wr_data", 32'(data_out[15:8]), 32'hA5);
    chk("nown_wr_cnt", 32'(err_cnt), 32'h1);
    req_a(OP_CLAIM, 2'd1, 2'd1, 8'h00);
    chk("nown_cl_err", 32'(rsp_err), 32'h1);
    chk("nown_cl_cnt", 32'(err_cnt), 32'h2);
    chk("nown_cl_owned", 32'(owned_vec), 32'h2);
    step();
    chk("idle_rspv", 32'(rsp_valid), 32'h0);
    chk("idle_err", 32'(rsp_err), 32'h0);

    // Lock, then write and release are both rejected
    req_a(OP_LOCK, 2'd1, 2'd2, 8'h00);
    chk("lock_rspv", 32'(rsp_valid), 32'h1);
    chk("lock_err", 32'(rsp_err), 32'h0);
    chk("lock_vec", 32'(locked_vec), 32'h2);
    req_a(OP_WRITE, 2'd1, 2'd2, 8'h00);
    chk("lk_wr_err", 32'(rsp_err), 32'h1);
    req_a(OP_RELEASE, 2'd1, 2'd2, 8'h00);
    chk("lk_rel_err", 32'(rsp_err), 32'h1);
    chk("lk_data", 32'(data_out[15:8]), 32'hA5);
    chk("lk_locked", 32'(locked_vec), 32'h2);
    chk("lk_owned", 32'(owned_vec), 32'h2);
    chk("lk_cnt", 32'(err_cnt), 32'h4);
    rd_addr = 2'd1;
    step();
    chk("lk_rd", 32'(rd_data), 32'hA5);

    // Reset clears the locked slot
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_owned", 32'(owned_vec), 32'h0);
    chk("rst2_locked", 32'(locked_vec), 32'h0);
    chk("rst2_dout", data_out, 32'h0);
    chk("rst2_cnt", 32'(err_cnt), 32'h0);
    chk("rst2_rd", 32'(rd_data), 32'h0);

    // Back-to-back claim/write/release by user 3 on slot 0, with read-before-write
    rd_addr = 2'd0;
    req_a(OP_CLAIM, 2'd0, 2'd3, 8'h00);
    req_valid = 1'b1; req_op = OP_WRITE; data_in = 8'h11;
    chk("b2b_cl_rspv", 32'(rsp_valid), 32'h1);
    chk("b2b_cl_err", 32'(rsp_err), 32'h0);
    chk("b2b_cl_owned", 32'(owned_vec), 32'h1);
    step();
    req_op = OP_RELEASE;
    chk("b2b_wr_rspv", 32'(rsp_valid), 32'h1);
    chk("b2b_wr_err", 32'(rsp_err), 32'h0);
    chk("b2b_wr_data", 32'(data_out[7:0]), 32'h11);
    chk("b2b_wr_rdold", 32'(rd_data), 32'h0);
    step();
    req_valid = 1'b0;
    chk("b2b_rel_rspv", 32'(rsp_valid), 32'h1);
    chk("b2b_rel_err", 32'(rsp_err), 32'h0);
    chk("b2b_rel_data", 32'(data_out[7:0]), 32'h0);
    chk("b2b_rel_owned", 32'(owned_vec), 32'h0);
    chk("b2b_rel_rdnew", 32'(rd_data), 32'h11);
    req_a(OP_LOCK, 2'd0, 2'd3, 8'h00);
    chk("free_lock_err", 32'(rsp_err), 32'h1);
    chk("free_lock_vec", 32'(locked_vec), 32'h0);
    chk("free_lock_cnt", 32'(err_cnt), 32'h1);
    step();
    chk("b2b_end_rspv", 32'(rsp_valid), 32'h0);
    chk("b2b_end_rd", 32'(rd_data), 32'h0);

    // Instance B: out-of-range address and counter saturation
    req_b(OP_CLAIM, 2'd2, 2'd0, 8'h00);
    chk("b_claim_err", 32'(rsp_err_b), 32'h0);
    chk("b_claim_owned", 32'(owned_vec_b), 32'h4);
    req_b(OP_WRITE, 2'd2, 2'd0, 8'h77);
    chk("b_wr_data", 32'(data_out_b), 32'h770000);
    req_b(OP_CLAIM, 2'd3, 2'd0, 8'h00);
    chk("b_oor_cl_rspv", 32'(rsp_valid_b), 32'h1);
    chk("b_oor_cl_err", 32'(rsp_err_b), 32'h1);
    chk("b_oor_cl_cnt", 32'(err_cnt_b), 32'h1);
    chk("b_oor_cl_owned", 32'(owned_vec_b), 32'h4);
    req_b(OP_WRITE, 2'd3, 2'd0, 8'hFF);
    chk("b_oor_wr_err", 32'(rsp_err_b), 32'h1);
    chk("b_oor_wr_cnt", 32'(err_cnt_b), 32'h2);
    chk("b_oor_wr_data", 32'(data_out_b), 32'h770000);
    req_b(OP_CLAIM, 2'd2, 2'd1, 8'h00);
    chk("b_sat3_cnt", 32'(err_cnt_b), 32'h3);
    req_b(OP_CLAIM, 2'd2, 2'd1, 8'h00);
    chk("b_sat4_cnt", 32'(err_cnt_b), 32'h3);
    req_b(OP_LOCK, 2'd2, 2'd1, 8'h00);
    chk("b_sat5_err", 32'(rsp_err_b), 32'h1);
    chk("b_sat5_cnt", 32'(err_cnt_b), 32'h3);
    chk("b_sat5_locked", 32'(locked_vec_b), 32'h0);
    rd_addr_b = 2'd3;
    step();
    chk("b_rd_oor", 32'(rd_data_b), 32'h0);
    rd_addr_b = 2'd2;
    step();
    chk("b_rd_2", 32'(rd_data_b), 32'h77);

    // Reset coinciding with a request drops it without a response
    rst_b = 1'b1; req_valid_b = 1'b1; req_op_b = OP_CLAIM; req_addr_b = 2'd0; usr_id_b = 2'd1;
    step();
    rst_b = 1'b0; req_valid_b = 1'b0;
    chk("b_rstreq_rspv", 32'(rsp_valid_b), 32'h0);
    chk("b_rstreq_owned", 32'(owned_vec_b), 32'h0);
    chk("b_rstreq_cnt", 32'(err_cnt_b), 32'h0);
    step();
    chk("b_rstreq_rspv2", 32'(rsp_valid_b), 32'h0);
    chk("b_rstreq_owned2", 32'(owned_vec_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/user_locked_regfile.md
# user_locked_regfile

Parametrised bank of user-owned data registers with per-register claim, release and sticky lock, gated by user ID. It generalises the single owner-gated register from a fixed user to dynamic ownership, and adds request/response signalling and violation counting. It sits between the bus-side user request decoder and the configuration consumers, which read the flat `data_out` bus.

## Interface
Parameters:
- `DATA_W`, 8, register width.
- `NUM_REGS`, 4, register count (≥1); `ADDR_W = max(1, $clog2(NUM_REGS))`, derived.
- `USR_W`, 2, user ID width.
- `CNT_W`, 8, violation counter width.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request strobe; one request accepted per cycle, no backpressure.
- `req_op`  in  2  0=WRITE, 1=CLAIM, 2=RELEASE, 3=LOCK.
- `req_addr`  in  ADDR_W  target register.
- `usr_id`  in  USR_W  requesting user.
- `data_in`  in  DATA_W  WRITE payload.
- `rsp_valid`  out  1  response strobe, one cycle after `req_valid`.
- `rsp_err`  out  1  request rejected (valid with `rsp_valid`).
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  registered read data.
- `data_out`  out  NUM_REGS*DATA_W  all registers, register i at bits [i*DATA_W +: DATA_W].
- `owned_vec`  out  NUM_REGS  slot in OWNED or LOCKED.
- `locked_vec`  out  NUM_REGS  slot in LOCKED.
- `err_cnt`  out  CNT_W  saturating count of rejected requests.

## Operation
- Per-slot FSM, states FREE, OWNED, LOCKED; each slot stores `owner` (USR_W) and `data` (DATA_W).
- CLAIM: FREE → OWNED, `owner <= usr_id`, ack. Any other state → err.
- WRITE: accepted only in OWNED with `usr_id == owner`; `data <= data_in`, ack. FREE, LOCKED or non-owner → err, data unchanged.
- RELEASE: OWNED with owner match → FREE, `data <= 0`, `owner <= 0`, ack. Otherwise → err.
- LOCK: OWNED with owner match → LOCKED, ack. Otherwise → err.
- LOCKED is sticky; only `rst` leaves it. Data stays readable.
- `req_addr >= NUM_REGS` → err, no slot affected.
- Every err increments `err_cnt`, which saturates at 2^CNT_W−1.
- `rd_data` gives the addressed slot's data. Out-of-range `rd_addr` gives 0. Reads are never restricted.

## Timing
- Reset (`rst`=1 at the edge) sets: all slots FREE, `data` 0, `owner` 0; `data_out` 0, `owned_vec` 0, `locked_vec` 0, `rd_data` 0, `rsp_valid` 0, `rsp_err` 0, `err_cnt` 0.
- Reset has priority. A request presented in a reset cycle is dropped with no response. Reset while a response is pending clears `rsp_valid` at that edge.
- Request latency:
  - Request sampled at edge N.
  - State, `data_out`, `owned_vec` and `locked_vec` update at edge N.
  - `rsp_valid`/`rsp_err` are high for the cycle after edge N.
  - `err_cnt` reflects the err after edge N.
- Back-to-back requests every cycle are legal. Each one sees the state left by its predecessor.
- `rsp_valid` is 0 in any cycle following `req_valid`=0. `rsp_err` is 0 whenever `rsp_valid` is 0.
- `rd_data` has one-cycle latency and is read-before-write: a read and a write to the same slot on the same edge return the old value. The new value is visible on the next read.
- `req_op`, `req_addr`, `usr_id` and `data_in` are don't-care when `req_valid`=0.

## Structure
- Package `user_lock_pkg`: op enum (`OP_WRITE`, `OP_CLAIM`, `OP_RELEASE`, `OP_LOCK`), slot state enum (`ST_FREE`, `ST_OWNED`, `ST_LOCKED`).
- Sub-module `user_lock_slot`: one FSM, owner and data register.
  - Inputs: `sel`, op, `usr_id`, data.
  - Outputs: ack/err, data, owned, locked.
  - Instantiated NUM_REGS times in a generate loop.
- Top level contains: address decode, out-of-range check, response register, saturating counter, read mux.

## Test plan
- Reset, then read all slots → `rd_data`=0, `owned_vec`=0, `locked_vec`=0, `err_cnt`=0, `rsp_valid`=0.
- User 2 CLAIM slot 1, then WRITE 0xA5 → two acks; `data_out[15:8]`=0xA5; `owned_vec`=4'b0010.
- User 1 WRITE 0x3C to slot 1 (owned by user 2) → `rsp_err`=1, data stays 0xA5, `err_cnt`=1. User 1 CLAIM slot 1 → err, `err_cnt`=2.
- User 2 LOCK slot 1, then WRITE 0x00 and RELEASE → lock acks. Both following requests err, data stays 0xA5, `locked_vec`=4'b0010. Assert `rst` → slot 1 FREE and data 0.
- User 3 CLAIM slot 0, WRITE 0x11, RELEASE, back-to-back → three acks on consecutive cycles. Data ends 0, slot FREE. A CLAIM with `req_addr` ≥ NUM_REGS (NUM_REGS=3) → err.
- With CNT_W=2, drive 5 err requests → `err_cnt` sticks at 3. Assert `rst` together with `req_valid` → no `rsp_valid` in the next cycle.
